mac_result_accumulator: RTL



---
 rtl/mac_result_accumulator.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mac_result_accumulator.sv
// rtl/mac_result_accumulator.sv - K-tile partial-sum accumulator with Q8.8 narrowing and output FIFO (optional saturation: ACC_OUT_SAT_EN)
module mac_result_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int TILE_SIZE  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int KT_WIDTH   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [KT_WIDTH-1:0]                    num_ktiles,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic signed [TILE_SIZE*DATA_WIDTH-1:0] in_vec,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [TILE_SIZE*DATA_WIDTH-1:0] out_vec,
    output logic                                   busy,
    output logic                                   group_done,
    output logic                                   sat_flag
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FILL_W = PTR_W + 1;
    localparam int EXT_W = ACC_WIDTH - DATA_WIDTH;
    localparam int VEC_W = TILE_SIZE * DATA_WIDTH;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [KT_WIDTH-1:0]    nkt_q, nkt_d;
    logic [KT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   acc_q [TILE_SIZE];
    logic [ACC_WIDTH-1:0]   acc_d [TILE_SIZE];
    logic [VEC_W-1:0]       mem_q [FIFO_DEPTH];
    logic [VEC_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   group_done_q, group_done_d;

    logic [ACC_WIDTH-1:0]   sum_w [TILE_SIZE];
    logic [DATA_WIDTH-1:0]  res_w [TILE_SIZE];
    logic [VEC_W-1:0]       push_vec;
    logic                   start_ok;
    logic                   accept;
    logic                   last_beat;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

`ifdef ACC_OUT_SAT_EN
    logic [TILE_SIZE-1:0]   clamp_w;
    logic                   sat_q, sat_d;
`endif

    assign fifo_full  = (fill_q == FILL_W'(FIFO_DEPTH));
    assign fifo_empty = (fill_q == '0);
    assign start_ok   = (state_q == IDLE) && start && (num_ktiles != '0);
    assign accept     = in_valid && in_ready;
    // cnt counts beats already absorbed, so the final beat is the one arriving at num_ktiles-1
    assign last_beat  = accept && (cnt_q == nkt_q - KT_WIDTH'(1));
    assign push       = last_beat;
    assign pop        = out_valid && out_ready;

    assign out_valid  = !fifo_empty;
    assign out_vec    = mem_q[rd_ptr_q];
    assign group_done = group_done_q;
`ifdef ACC_OUT_SAT_EN
    assign sat_flag   = sat_q;
`else
    assign sat_flag   = 1'b0;
`endif

    // State register plus all datapath flops; reset discards any in-flight group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            nkt_q        <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            group_done_q <= 1'b0;
            for (int k = 0; k < TILE_SIZE; k++) acc_q[k] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef ACC_OUT_SAT_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            nkt_q        <= nkt_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            group_done_q <= group_done_d;
            for (int k = 0; k < TILE_SIZE; k++) acc_q[k] <= acc_d[k];
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef ACC_OUT_SAT_EN
            sat_q        <= sat_d;
`endif
        end
    end

    // Next state: a nonzero start opens a group, the final beat closes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = ACCUM;
            ACCUM:   if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: back-pressure the array whenever the FIFO has no room for a result
    always_comb begin
        busy     = (state_q == ACCUM);
        in_ready = (state_q == ACCUM) && !fifo_full;
    end

    // Per-element wide sum and its narrowed Q8.8 form
    always_comb begin
        push_vec = '0;
`ifdef ACC_OUT_SAT_EN
        clamp_w  = '0;
`endif
        for (int k = 0; k < TILE_SIZE; k++) begin
            sum_w[k] = acc_q[k] + {{EXT_W{in_vec[k*DATA_WIDTH+DATA_WIDTH-1]}},
                                   in_vec[k*DATA_WIDTH +: DATA_WIDTH]};
`ifdef ACC_OUT_SAT_EN
            // In range exactly when every bit above the Q8.8 sign bit matches the sign
            if (sum_w[k][ACC_WIDTH-1:DATA_WIDTH-1] == {(EXT_W+1){sum_w[k][ACC_WIDTH-1]}}) begin
                res_w[k] = sum_w[k][DATA_WIDTH-1:0];
            end else begin
                clamp_w[k] = 1'b1;
                res_w[k]   = sum_w[k][ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
`else
            res_w[k] = sum_w[k][DATA_WIDTH-1:0];
`endif
            push_vec[k*DATA_WIDTH +: DATA_WIDTH] = res_w[k];
        end
    end

    // Accumulator, beat counter and group bookkeeping
    always_comb begin
        nkt_d        = nkt_q;
        cnt_d        = cnt_q;
        group_done_d = push;
        for (int k = 0; k < TILE_SIZE; k++) acc_d[k] = acc_q[k];
`ifdef ACC_OUT_SAT_EN
        sat_d        = sat_q | (push && (|clamp_w));
`endif
        if (start_ok) begin
            nkt_d = num_ktiles;
            cnt_d = '0;
            for (int k = 0; k < TILE_SIZE; k++) acc_d[k] = '0;
        end else if (accept) begin
            cnt_d = last_beat ? '0 : cnt_q + KT_WIDTH'(1);
            for (int k = 0; k < TILE_SIZE; k++) acc_d[k] = last_beat ? '0 : sum_w[k];
        end
    end

    // Output FIFO: simultaneous push and pop both happen, occupancy unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        if (push) begin
            mem_d[wr_ptr_q] = push_vec;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

endmodule
